// File: rtl/tweak_sequencer_pkg.sv
// Shared encodings, state enum and instruction field helpers
// for the tweakpu sequencer.
package tweakpu_pkg;

    localparam logic [1:0] ENC_0OP = 2'b00;
    localparam logic [1:0] ENC_1OP = 2'b01;
    localparam logic [1:0] ENC_2OP = 2'b10;
    localparam logic [1:0] ENC_3OP = 2'b11;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_JMP  = 6'h01;
    localparam logic [5:0] OP_HALT = 6'h3F;
    localparam logic [5:0] OP_LDI  = 6'h00;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        RD_A,
        RD_B,
        EXEC,
        WB,
        HALT
    } state_t;

    // rd sits in a different nibble for each encoding
    function automatic logic [3:0] f_rd(input logic [31:0] ins);
        logic [3:0] r;
        r = 4'd0;
        unique case (ins[31:30])
            ENC_1OP: r = ins[23:20];
            ENC_2OP: r = ins[7:4];
            ENC_3OP: r = ins[11:8];
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] f_ra(input logic [31:0] ins);
        logic [3:0] r;
        r = 4'd0;
        unique case (ins[31:30])
            ENC_2OP: r = ins[3:0];
            ENC_3OP: r = ins[7:4];
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] f_rb(input logic [31:0] ins);
        return ins[3:0];
    endfunction

    function automatic logic [31:0] f_imm(input logic [31:0] ins);
        return {12'd0, ins[19:0]};
    endfunction

endpackage

// File: rtl/tweak_sequencer_if.sv
// Instruction-memory, register-file and ALU bus
// between the sequencer and the tweakpu datapath.
interface tweak_sequencer_if #(
    parameter int PCW = 4
);
    logic            imem_req;
    logic [PCW-1:0]  imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_data;

    logic            rf_en;
    logic            rf_we;
    logic [3:0]      rf_addr;
    logic [31:0]     rf_wdata;
    logic [31:0]     rf_rdata;

    logic            alu_go;
    logic [5:0]      alu_icode;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [31:0]     alu_res;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output rf_en, rf_we, rf_addr, rf_wdata,
        input  rf_rdata,
        output alu_go, alu_icode, alu_a, alu_b,
        input  alu_res
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  rf_en, rf_we, rf_addr, rf_wdata,
        output rf_rdata,
        input  alu_go, alu_icode, alu_a, alu_b,
        output alu_res
    );

endinterface

// File: rtl/tweak_sequencer_dec.sv
// Combinational instruction field decoder.
// Exactly one is_* flag is high for any word.
module tweak_sequencer_dec
    import tweakpu_pkg::*;
(
    input  logic [31:0] ins,
    output logic        is_nop,
    output logic        is_jmp,
    output logic        is_halt,
    output logic        is_ldi,
    output logic        is_alu2,
    output logic        is_alu3,
    output logic [5:0]  icode,
    output logic [3:0]  rd,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [31:0] imm
);

    always_comb begin
        is_nop  = 1'b0;
        is_jmp  = 1'b0;
        is_halt = 1'b0;
        is_ldi  = 1'b0;
        is_alu2 = 1'b0;
        is_alu3 = 1'b0;
        icode   = ins[29:24];
        rd      = f_rd(ins);
        ra      = f_ra(ins);
        rb      = f_rb(ins);
        imm     = f_imm(ins);
        // unknown icodes in the 0/1-operand spaces fall back to NOP
        unique case (ins[31:30])
            ENC_0OP: begin
                if (icode == OP_JMP)       is_jmp  = 1'b1;
                else if (icode == OP_HALT) is_halt = 1'b1;
                else                       is_nop  = 1'b1;
            end
            ENC_1OP: begin
                if (icode == OP_LDI) is_ldi = 1'b1;
                else                 is_nop = 1'b1;
            end
            ENC_2OP: is_alu2 = 1'b1;
            ENC_3OP: is_alu3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/tweak_sequencer.sv
// Multi-cycle fetch/decode/execute controller for tweakpu.
// One instruction in flight; pc and operand latches live here.
module tweak_sequencer
    import tweakpu_pkg::*;
#(
    parameter int             PCW      = 4,
    parameter logic [PCW-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                run,
    tweak_sequencer_if.master   bus,
    output logic [PCW-1:0]      pc,
    output logic                halted
);

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [31:0]    ir_q, ir_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;

    logic           is_nop, is_jmp, is_halt;
    logic           is_ldi, is_alu2, is_alu3;
    logic [5:0]     icode;
    logic [3:0]     rd, ra, rb;
    logic [31:0]    imm;

    logic [PCW-1:0] pc_inc;
    state_t         st_bound;

    tweak_sequencer_dec u_dec (
        .ins     (ir_q),
        .is_nop  (is_nop),
        .is_jmp  (is_jmp),
        .is_halt (is_halt),
        .is_ldi  (is_ldi),
        .is_alu2 (is_alu2),
        .is_alu3 (is_alu3),
        .icode   (icode),
        .rd      (rd),
        .ra      (ra),
        .rb      (rb),
        .imm     (imm)
    );

    assign pc_inc   = pc_q + PCW'(1);
    assign st_bound = run ? FETCH : IDLE;
    assign pc       = pc_q;
    assign halted   = (state_q == HALT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        a_d           = a_q;
        b_d           = b_q;
        bus.imem_req  = 1'b0;
        bus.imem_addr = pc_q;
        bus.rf_en     = 1'b0;
        bus.rf_we     = 1'b0;
        bus.rf_addr   = 4'd0;
        bus.rf_wdata  = 32'd0;
        bus.alu_go    = 1'b0;
        bus.alu_icode = 6'd0;
        bus.alu_a     = a_q;
        bus.alu_b     = b_q;

        unique case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                unique case (1'b1)
                    is_halt: state_d = HALT;
                    is_jmp: begin
                        pc_d    = imm[PCW-1:0];
                        state_d = st_bound;
                    end
                    is_ldi:  state_d = WB;
                    is_alu2: state_d = RD_A;
                    is_alu3: state_d = RD_A;
                    is_nop: begin
                        pc_d    = pc_inc;
                        state_d = st_bound;
                    end
                    default: state_d = IDLE;
                endcase
            end
            RD_A: begin
                bus.rf_en   = 1'b1;
                bus.rf_addr = ra;
                state_d     = is_alu3 ? RD_B : EXEC;
            end
            RD_B: begin
                a_d         = bus.rf_rdata;
                bus.rf_en   = 1'b1;
                bus.rf_addr = rb;
                state_d     = EXEC;
            end
            EXEC: begin
                // last read lands now; pass it straight to the ALU
                bus.alu_go    = 1'b1;
                bus.alu_icode = icode;
                if (is_alu3) begin
                    b_d       = bus.rf_rdata;
                    bus.alu_b = bus.rf_rdata;
                end else begin
                    a_d       = bus.rf_rdata;
                    b_d       = 32'd0;
                    bus.alu_a = bus.rf_rdata;
                    bus.alu_b = 32'd0;
                end
                state_d = WB;
            end
            WB: begin
                bus.rf_en    = 1'b1;
                bus.rf_we    = 1'b1;
                bus.rf_addr  = rd;
                bus.rf_wdata = is_ldi ? imm : bus.alu_res;
                pc_d         = pc_inc;
                state_d      = st_bound;
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tweak_sequencer.sv
// Directed bench for tweak_sequencer with imem, regfile
// and ALU models on the slave side of the bus.
module tb_tweak_sequencer;

    logic       CLK;
    logic       RESET;
    logic       run;
    logic [3:0] pc;
    logic       halted;

    tweak_sequencer_if #(.PCW(4)) sq_if ();

    tweak_sequencer #(
        .PCW      (4),
        .RESET_PC (4'd0)
    ) u_dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .run    (run),
        .bus    (sq_if),
        .pc     (pc),
        .halted (halted)
    );

    logic [31:0] mem [16];
    logic [31:0] regs [16];
    int          ack_dly;
    int          ack_cnt;
    int          wr_cnt;
    int          req_cnt;
    int          cyc;
    int          checks;
    int          errors;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // garbage without ack is a HALT word, so it must be ignored
    assign sq_if.imem_ack  = sq_if.imem_req && (ack_cnt == ack_dly);
    assign sq_if.imem_data = sq_if.imem_ack ?
                             mem[sq_if.imem_addr] : 32'h3F00_0000;

    always @(posedge CLK) begin
        if (RESET) begin
            ack_cnt        <= 0;
            sq_if.rf_rdata <= 32'd0;
            sq_if.alu_res  <= 32'd0;
        end else begin
            if (sq_if.imem_ack)     ack_cnt <= 0;
            else if (sq_if.imem_req) ack_cnt <= ack_cnt + 1;
            if (sq_if.rf_en && !sq_if.rf_we)
                sq_if.rf_rdata <= regs[sq_if.rf_addr];
            if (sq_if.rf_en && sq_if.rf_we)
                regs[sq_if.rf_addr] <= sq_if.rf_wdata;
            if (sq_if.alu_go)
                sq_if.alu_res <= sq_if.alu_a + sq_if.alu_b
                               + {26'd0, sq_if.alu_icode};
        end
    end

    always @(negedge CLK) begin
        if (sq_if.rf_en && sq_if.rf_we) wr_cnt <= wr_cnt + 1;
        if (sq_if.imem_req)             req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic wait_req(input logic [3:0] a, output int t);
        int n;
        n = 0;
        while (!(sq_if.imem_req && sq_if.imem_addr == a) && n < 30) begin
            step();
            n++;
        end
        chk("fetch_seen", 32'(n < 30), 32'd1);
        t = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, t3, t4, w;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        wr_cnt  = 0;
        req_cnt = 0;
        ack_dly = 0;
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 32'd0;
            regs[i] = 32'd0;
        end
        regs[1] = 32'd7;
        regs[2] = 32'd5;
        mem[0]  = 32'h4050_0001;
        mem[1]  = 32'hC000_0312;
        mem[2]  = 32'h0100_000E;

        RESET = 1'b1;
        run   = 1'b0;
        step();
        step();
        RESET = 1'b0;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_req", 32'(sq_if.imem_req), 32'd0);
        chk("rst_rf_en", 32'(sq_if.rf_en), 32'd0);
        chk("rst_alu_go", 32'(sq_if.alu_go), 32'd0);
        chk("rst_alu_a", sq_if.alu_a, 32'd0);
        chk("rst_wdata", sq_if.rf_wdata, 32'd0);

        // LDI r5,1
        run = 1'b1;
        wait_req(4'd0, t0);
        step();
        step();
        chk("ldi_en", 32'(sq_if.rf_en), 32'd1);
        chk("ldi_we", 32'(sq_if.rf_we), 32'd1);
        chk("ldi_addr", 32'(sq_if.rf_addr), 32'd5);
        chk("ldi_wdata", sq_if.rf_wdata, 32'd1);
        step();
        chk("ldi_next_addr", 32'(sq_if.imem_addr), 32'd1);
        chk("ldi_pc", 32'(pc), 32'd1);
        chk("ldi_lat", 32'(cyc - t0), 32'd3);
        chk("ldi_wr_cnt", 32'(wr_cnt), 32'd1);

        // ADD r3,r1,r2
        t1 = cyc;
        step();
        step();
        chk("add_rda_en", 32'(sq_if.rf_en), 32'd1);
        chk("add_rda_we", 32'(sq_if.rf_we), 32'd0);
        chk("add_rda_addr", 32'(sq_if.rf_addr), 32'd1);
        step();
        chk("add_rdb_addr", 32'(sq_if.rf_addr), 32'd2);
        step();
        chk("add_go", 32'(sq_if.alu_go), 32'd1);
        chk("add_a", sq_if.alu_a, 32'd7);
        chk("add_b", sq_if.alu_b, 32'd5);
        chk("add_icode", 32'(sq_if.alu_icode), 32'd0);
        step();
        chk("add_wb_we", 32'(sq_if.rf_we), 32'd1);
        chk("add_wb_addr", 32'(sq_if.rf_addr), 32'd3);
        chk("add_wb_data", sq_if.rf_wdata, 32'd12);

        // JMP 14, NOP at 14 and 15, wrap to 0
        wait_req(4'd2, t2);
        chk("add_lat", 32'(t2 - t1), 32'd6);
        step();
        step();
        chk("jmp_addr", 32'(sq_if.imem_addr), 32'd14);
        chk("jmp_pc", 32'(pc), 32'd14);
        chk("jmp_req", 32'(sq_if.imem_req), 32'd1);
        step();
        step();
        chk("nop_addr", 32'(sq_if.imem_addr), 32'd15);
        run = 1'b0;
        step();
        step();
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_idle_req", 32'(sq_if.imem_req), 32'd0);
        chk("jmp_nop_no_wr", 32'(wr_cnt), 32'd2);

        // 2-operand op with a 3-cycle ack delay
        mem[0]  = 32'h9000_0061;
        ack_dly = 3;
        run     = 1'b1;
        wait_req(4'd0, t3);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("dly_req", 32'(sq_if.imem_req), 32'd1);
            chk("dly_addr", 32'(sq_if.imem_addr), 32'd0);
        end
        step();
        ack_dly = 0;
        chk("dly_dec_req", 32'(sq_if.imem_req), 32'd0);
        chk("dly_no_halt", 32'(halted), 32'd0);
        step();
        chk("op2_rda_addr", 32'(sq_if.rf_addr), 32'd1);
        step();
        chk("op2_go", 32'(sq_if.alu_go), 32'd1);
        chk("op2_a", sq_if.alu_a, 32'd7);
        chk("op2_b", sq_if.alu_b, 32'd0);
        chk("op2_icode", 32'(sq_if.alu_icode), 32'h10);
        step();
        chk("op2_wb_addr", 32'(sq_if.rf_addr), 32'd6);
        chk("op2_wb_data", sq_if.rf_wdata, 32'h17);
        step();
        chk("op2_lat", 32'(cyc - t3), 32'd8);
        chk("op2_next_pc", 32'(pc), 32'd1);

        // run dropped during RD_B: WB still occurs
        step();
        step();
        step();
        chk("drop_rdb_addr", 32'(sq_if.rf_addr), 32'd2);
        run = 1'b0;
        step();
        chk("drop_go", 32'(sq_if.alu_go), 32'd1);
        step();
        chk("drop_wb_we", 32'(sq_if.rf_we), 32'd1);
        chk("drop_wb_addr", 32'(sq_if.rf_addr), 32'd3);
        chk("drop_wb_data", sq_if.rf_wdata, 32'd12);
        step();
        chk("drop_idle_req", 32'(sq_if.imem_req), 32'd0);
        chk("drop_pc", 32'(pc), 32'd2);
        step();
        chk("drop_stay_idle", 32'(sq_if.imem_req), 32'd0);
        chk("drop_wr_cnt", 32'(wr_cnt), 32'd4);

        // HALT parks until reset
        mem[2] = 32'h3F00_0000;
        run    = 1'b1;
        wait_req(4'd2, t4);
        step();
        step();
        chk("halt_flag", 32'(halted), 32'd1);
        w = req_cnt;
        for (int k = 0; k < 5; k++) step();
        chk("halt_no_req", 32'(req_cnt - w), 32'd0);
        chk("halt_flag_hold", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd2);
        RESET = 1'b1;
        run   = 1'b0;
        step();
        RESET = 1'b0;
        chk("halt_rst_flag", 32'(halted), 32'd0);
        chk("halt_rst_pc", 32'(pc), 32'd0);
        chk("halt_rst_req", 32'(sq_if.imem_req), 32'd0);

        // RESET in EXEC abandons the write-back
        mem[0] = 32'hC000_0412;
        run    = 1'b1;
        wait_req(4'd0, t4);
        for (int k = 0; k < 4; k++) step();
        chk("rx_go", 32'(sq_if.alu_go), 32'd1);
        w     = wr_cnt;
        RESET = 1'b1;
        run   = 1'b0;
        step();
        RESET = 1'b0;
        chk("rx_rf_en", 32'(sq_if.rf_en), 32'd0);
        chk("rx_rf_we", 32'(sq_if.rf_we), 32'd0);
        chk("rx_go_off", 32'(sq_if.alu_go), 32'd0);
        chk("rx_alu_a", sq_if.alu_a, 32'd0);
        chk("rx_alu_b", sq_if.alu_b, 32'd0);
        chk("rx_icode", 32'(sq_if.alu_icode), 32'd0);
        chk("rx_wdata", sq_if.rf_wdata, 32'd0);
        chk("rx_req", 32'(sq_if.imem_req), 32'd0);
        chk("rx_pc", 32'(pc), 32'd0);
        for (int k = 0; k < 3; k++) step();
        chk("rx_no_wb", 32'(wr_cnt - w), 32'd0);
        chk("rx_r4", regs[4], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
